// File: rtl/mux_8_to_1_scanner_if.sv
// rtl/mux_8_to_1_scanner_if.sv - lane and output-line handshake bundle for the 8-to-1 scanner
interface mux_8_to_1_scanner_if #(
    parameter int WIDTH = 1
);
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ack;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_select;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ack, out_data, out_select, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ack, out_data, out_select, out_valid
    );
endinterface

// File: rtl/mux_8_to_1_scanner.sv
// rtl/mux_8_to_1_scanner.sv - round-robin 8-to-1 mux with lane-tagged registered output
module mux_8_to_1_scanner #(
    parameter int WIDTH = 1
) (
    input logic clk,
    input logic reset,
    mux_8_to_1_scanner_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       select_q;

    logic       load;
    logic       found;
    logic [2:0] lane;

    // First valid lane at or after ptr, wrapping modulo 8.
    always_comb begin
        load  = (state == EMPTY) || bus.out_ready;
        found = 1'b0;
        lane  = ptr;
        for (int i = 0; i < 8; i++) begin
            if (!found && bus.in_valid[ptr + 3'(i)]) begin
                found = 1'b1;
                lane  = ptr + 3'(i);
            end
        end
    end

    assign bus.in_ack     = (load && found && !reset) ? (8'd1 << lane) : 8'd0;
    assign bus.out_valid  = (state == FULL);
    assign bus.out_data   = data_q;
    assign bus.out_select = select_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            ptr      <= 3'd0;
            data_q   <= '0;
            select_q <= 3'd0;
        end else if (load) begin
            if (found) begin
                state    <= FULL;
                data_q   <= bus.in_data[lane*WIDTH +: WIDTH];
                select_q <= lane;
                ptr      <= lane + 3'd1;
            end else begin
                state <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_mux_8_to_1_scanner.sv
// tb/tb_mux_8_to_1_scanner.sv - self-checking bench for mux_8_to_1_scanner
module tb_mux_8_to_1_scanner;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;

    mux_8_to_1_scanner_if #(.WIDTH(W)) bus ();

    mux_8_to_1_scanner #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int           m_ptr;
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    logic [7:0]   last_ack;
    logic [7:0]   pat;
    logic [7:0]   dm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] v, input int p);
        for (int i = 0; i < 8; i++)
            if (v[(p + i) % 8]) return (p + i) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
    endtask

    task automatic cyc();
        logic [7:0] e_ack;
        int         g;
        logic       ld;
        @(negedge clk);
        ld    = !m_valid || bus.out_ready;
        g     = pick(bus.in_valid, m_ptr);
        e_ack = (!reset && ld && g >= 0) ? 8'(1 << g) : 8'h00;
        last_ack = bus.in_ack;
        chk("ack", {24'd0, bus.in_ack}, {24'd0, e_ack});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("out_select", {29'd0, bus.out_select}, 32'(m_sel));
        @(posedge clk);
        if (!reset && ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = bus.in_data[g*W +: W];
                m_sel   = g;
                m_ptr   = (g + 1) % 8;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 8'hFF;
        bus.in_data   = 32'(W*8)'($urandom);
        bus.out_ready = 1'b1;
        model_reset();
        #2;
        chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_data", 32'(bus.out_data), 32'd0);
        chk("reset_select", {29'd0, bus.out_select}, 32'd0);
        chk("reset_ack", {24'd0, bus.in_ack}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.in_valid = 8'h00;

        // single lane: ack in t, word in t+1, empty in t+2
        bus.in_data = '0;
        bus.in_data[5*W +: W] = W'(1);
        bus.in_valid = 8'h20;
        cyc();
        chk("single_ack", {24'd0, last_ack}, 32'h20);
        chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("single_sel", {29'd0, bus.out_select}, 32'd5);
        chk("single_data", 32'(bus.out_data), 32'd1);
        bus.in_valid = 8'h00;
        cyc();
        chk("single_drain", {31'd0, bus.out_valid}, 32'd0);

        // all lanes at full rate
        reset_pulse();
        bus.in_data  = 32'(W*8)'($urandom);
        bus.in_valid = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("fullrate_sel", {29'd0, bus.out_select}, 32'(i % 8));
            chk("fullrate_valid", {31'd0, bus.out_valid}, 32'd1);
        end

        // wrap: serve lane 6, then 7 before 2, ptr lands on 3
        reset_pulse();
        bus.in_valid = 8'h40;
        cyc();
        bus.in_valid = 8'h84;
        cyc();
        chk("wrap_first", {24'd0, last_ack}, 32'h80);
        bus.in_valid = 8'h04;
        cyc();
        chk("wrap_second", {24'd0, last_ack}, 32'h04);
        bus.in_valid = 8'h09;
        cyc();
        chk("wrap_ptr3", {24'd0, last_ack}, 32'h08);

        // backpressure while holding lane 3's word
        bus.out_ready = 1'b0;
        bus.in_valid  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_ack", {24'd0, last_ack}, 32'd0);
            chk("stall_sel", {29'd0, bus.out_select}, 32'd3);
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        cyc();
        chk("release_ack", {24'd0, last_ack}, 32'h10);
        chk("release_sel", {29'd0, bus.out_select}, 32'd4);

        // loopback through a behavioural 1-to-8 demux
        pat = 8'b1010_0110;
        for (int k = 0; k < 8; k++) bus.in_data[k*W +: W] = W'(pat[k]);
        bus.in_valid = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (bus.out_valid) begin
                dm = 8'h00;
                dm[bus.out_select] = bus.out_data[0];
                chk("loopback", {31'd0, dm[bus.out_select]}, {31'd0, pat[bus.out_select]});
            end
        end

        // asynchronous reset mid-cycle while FULL
        #3 reset = 1'b1;
        #1;
        chk("async_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_data", 32'(bus.out_data), 32'd0);
        chk("async_select", {29'd0, bus.out_select}, 32'd0);
        chk("async_ack", {24'd0, bus.in_ack}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        bus.in_valid = 8'h01;
        cyc();
        chk("post_reset_ack", {24'd0, last_ack}, 32'h01);
        chk("post_reset_sel", {29'd0, bus.out_select}, 32'd0);
        chk("post_reset_valid", {31'd0, bus.out_valid}, 32'd1);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 8'($urandom);
            bus.in_data   = 32'(W*8)'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_8_to_1_scanner.md
# mux_8_to_1_scanner

Round-robin 8-to-1 multiplexer that gathers data from eight input lanes onto a single registered output line. Each output word is tagged with the 3-bit index of the lane it came from. It is the collecting end of the `demultiplexer_1_to_8` path. Driving `out_data`/`out_select` into the demultiplexer's `in`/`select_lines` routes every word back to the lane it left from. A valid/ready handshake on the output side and a per-lane valid/ack handshake on the input side let lanes with different rates share the line fairly.

## Interface
- `WIDTH`, default 1: data bits per lane and on the output line.

- `clk`  input  1: single clock, rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `in_data`  input  8*WIDTH: lane k data is `in_data[k*WIDTH +: WIDTH]`.
- `in_valid`  input  8: lane k has a word pending.
- `in_ack`  output  8: one-hot, combinational; lane k's word is captured at the end of this cycle.
- `out_data`  output  WIDTH: registered data of the selected lane.
- `out_select`  output  3: registered index of the lane that supplied `out_data`.
- `out_valid`  output  1: `out_data`/`out_select` hold a word.
- `out_ready`  input  1: downstream accepts the word this cycle.

## Operation
- State:
  - `ptr` (3 bits), the round-robin start lane.
  - One output register: `out_data`, `out_select`, `out_valid`.
- Two states, tracked by `out_valid`:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- `load` = EMPTY, or FULL with `out_ready`=1.
- Grant:
  - When `load`=1 and any `in_valid` bit is set, the granted lane is the first set bit scanning ptr, ptr+1, … ptr+7, all modulo 8.
  - `in_ack[lane]`=1; all other ack bits are 0.
- On the clock edge with a grant:
  - `out_data` ← the granted lane's slice.
  - `out_select` ← lane.
  - `out_valid` ← 1.
  - `ptr` ← (lane+1) mod 8, wrapping 7→0.
- On the clock edge with `load`=1 and no `in_valid`:
  - `out_valid` ← 0, i.e. FULL→EMPTY after acceptance, or stay EMPTY.
  - `out_data`, `out_select` and `ptr` are unchanged.
- FULL with `out_ready`=0 (stall):
  - All registers hold.
  - `in_ack`=0.
  - `in_valid`/`in_data` are ignored.
- Lane contract: a lane holds `in_valid` and its data stable until it sees `in_ack`. It may present the next word in the following cycle.
- Simultaneous accept and grant in FULL: the old word leaves and the new word loads on the same edge, with no bubble.
- `in_valid` deasserted before ack: that lane is simply not granted, with no error.

## Timing
- Reset (asynchronous assertion, registers clear immediately):
  - `out_valid`=0, `out_data`=0, `out_select`=0, `ptr`=0.
  - `in_ack` is forced to 0 while `reset`=1.
- Reset mid-operation: any word held in the output register is discarded.
- After `reset` deasserts, the first grant is evaluated in the first clock cycle.
- Latency: `in_valid` rises in cycle t with the block EMPTY → `in_ack` in cycle t → `out_valid`=1 in cycle t+1.
- Throughput: one word per cycle while `out_ready`=1 and any lane is valid.
- Fairness: a continuously valid lane is granted within 8 grants.
- `out_data`/`out_select` change only on a `load` edge with a grant, never during a stall.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle with the block FULL → `out_valid`=0, `out_data`=0, `out_select`=0 immediately. After release, with `in_valid`=8'h01, the first word comes from lane 0.
- **Single lane:** WIDTH=1, `in_valid`=8'h20, lane 5 data=1, `out_ready`=1 → `in_ack`=8'h20 in cycle t; `out_valid`=1, `out_select`=5, `out_data`=1 in t+1; `out_valid`=0 in t+2.
- **All lanes, full rate:** `in_valid`=8'hFF held, `out_ready`=1 → `out_select` sequence 0,1,…,7,0,1 on consecutive cycles with no bubbles.
- **Round-robin wrap:** after lane 6 is served (`ptr`=7), raise `in_valid`=8'h84 → lane 7 is granted first, then lane 2, and `ptr` ends at 3.
- **Backpressure:** FULL with `out_select`=3, `out_ready`=0 for 4 cycles while `in_valid`=8'hFF → outputs stable and `in_ack`=0 throughout. When `out_ready` rises, lane 4 is acked in that same cycle.
- **Loopback:** connect `out_data`/`out_select` to `demultiplexer_1_to_8` with `in_valid`=8'hFF and `in_data`=8'b1010_0110 → the demux output bit at `out_select` equals lane bit `out_select` on every valid cycle.
